fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the main control decoder. Holds the PC, issues requests to instruction memory through a request/ready handshake, and loads the IF/ID pipeline register, which presents the opcode and funct fields to the decoder and the PC+4 value to decode. Handles stall, flush and jump/branch redirect from the hazard and branch logic.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants, instruction field positions and fetch FSM
//                state encoding for the pipelined MIPS core.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_BOOT = 2'd0;
    localparam fetch_state_t FETCH_REQ  = 2'd1;
    localparam fetch_state_t FETCH_HOLD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : Pipeline register with hold, flush and load; a cycle that
//                neither holds nor loads captures a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    // Priority: reset > flush > hold > load > bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= NOP_INSTR;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (hold) begin
            instr <= instr;
            pc4   <= pc4;
            valid <= valid;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end else begin
            instr <= NOP_INSTR;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: PC, imem request/ready handshake, IF/ID
//                register, stall/flush/redirect. FETCH_PERF_EN adds counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect_target;
    logic         w_redirect;
    logic         w_transfer;
    logic         w_accept;

    assign w_redirect        = jump || branch_taken;
    assign w_redirect_target = (jump ? jump_target : branch_target) & ~32'h3;
    assign w_pc_plus4        = r_pc + PC_STEP;
    assign w_transfer        = imem_req && imem_ready;
    // A transfer only counts when neither a redirect nor a stall discards it
    assign w_accept          = w_transfer && !stall && !w_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_redirect) begin
            w_state_next = FETCH_REQ;
        end else begin
            case (r_state)
                FETCH_BOOT: w_state_next = stall ? FETCH_HOLD : FETCH_REQ;
                FETCH_REQ:  w_state_next = stall ? FETCH_HOLD : FETCH_REQ;
                FETCH_HOLD: w_state_next = stall ? FETCH_HOLD : FETCH_REQ;
                default:    w_state_next = FETCH_BOOT;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        if (r_state == FETCH_REQ) begin
            imem_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_redirect_target;
        end else if (w_accept) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign imem_addr = r_pc;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall),
        .flush    (flush || w_redirect),
        .load     (w_transfer),
        .instr_in (imem_rdata),
        .pc4_in   (w_pc_plus4),
        .instr    (id_instr),
        .pc4      (id_pc4),
        .valid    (id_valid)
    );

    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (w_accept) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0A5C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .id_instr      (id_instr),
        .id_pc4        (id_pc4),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = 32'd0; branch_target = 32'd0; imem_ready = 1'b1;
        step(); step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        total++; if (id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", id_instr); end
        total++; if (id_pc4 !== 32'h0) begin bad++; $display("FAIL reset_pc4: got %h want 0", id_pc4); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        total++; if ({id_opcode, id_funct} !== 12'h0) begin bad++; $display("FAIL reset_fields: got %h want 0", {id_opcode, id_funct}); end
        rst = 1'b0;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %b want 0", imem_req); end
        step();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            total++; if (imem_addr !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, 32'(4 * i)); end
            step();
            w = mem_word(32'(4 * i));
            total++; if (id_pc4 !== 32'(4 * i + 4)) begin bad++; $display("FAIL seq_pc4%0d: got %h want %h", i, id_pc4, 32'(4 * i + 4)); end
            total++; if (id_instr !== w) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", i, id_instr, w); end
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d: got %b want 1", i, id_valid); end
            total++; if (id_opcode !== w[31:26] || id_funct !== w[5:0]) begin bad++; $display("FAIL seq_fields%0d: got %h/%h want %h/%h", i, id_opcode, id_funct, w[31:26], w[5:0]); end
        end
    endtask

    task automatic test_not_ready();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL nr_addr%0d: got %h want 10", i, imem_addr); end
            total++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin bad++; $display("FAIL nr_bubble%0d: got %b/%h want 0/0", i, id_valid, id_instr); end
        end
        imem_ready = 1'b1;
        step();
        total++; if (id_instr !== mem_word(32'h10)) begin bad++; $display("FAIL nr_instr: got %h want %h", id_instr, mem_word(32'h10)); end
        total++; if (id_pc4 !== 32'h14 || id_valid !== 1'b1) begin bad++; $display("FAIL nr_pc4: got %h/%b want 14/1", id_pc4, id_valid); end
    endtask

    task automatic test_stall();
        step(); step(); step();
        total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL st_pre_addr: got %h want 20", imem_addr); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_req%0d: got %b want 0", i, imem_req); end
            total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL st_addr%0d: got %h want 20", i, imem_addr); end
            total++; if (id_instr !== mem_word(32'h1C) || id_pc4 !== 32'h20) begin bad++; $display("FAIL st_hold%0d: got %h/%h want %h/20", i, id_instr, id_pc4, mem_word(32'h1C)); end
        end
        stall = 1'b0;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin bad++; $display("FAIL st_resume: got %b/%h want 1/20", imem_req, imem_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL st_resume_bubble: got %b want 0", id_valid); end
        step();
        total++; if (id_instr !== mem_word(32'h20) || id_pc4 !== 32'h24) begin bad++; $display("FAIL st_next: got %h/%h want %h/24", id_instr, id_pc4, mem_word(32'h20)); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL br_addr: got %h want 100", imem_addr); end
        total++; if (id_instr !== 32'h0 || id_valid !== 1'b0) begin bad++; $display("FAIL br_bubble: got %h/%b want 0/0", id_instr, id_valid); end
        step();
        total++; if (id_instr !== mem_word(32'h100) || id_pc4 !== 32'h104) begin bad++; $display("FAIL br_target_instr: got %h/%h want %h/104", id_instr, id_pc4, mem_word(32'h100)); end
    endtask

    task automatic test_jump_stall();
        jump = 1'b1; jump_target = 32'h400; branch_taken = 1'b1; branch_target = 32'h200; stall = 1'b1;
        step();
        jump = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        total++; if (imem_addr !== 32'h400) begin bad++; $display("FAIL js_addr: got %h want 400", imem_addr); end
        total++; if (id_instr !== 32'h0 || id_valid !== 1'b0) begin bad++; $display("FAIL js_bubble: got %h/%b want 0/0", id_instr, id_valid); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL js_state_req: got %b want 1", imem_req); end
        step();
        total++; if (id_instr !== mem_word(32'h400) || id_pc4 !== 32'h404) begin bad++; $display("FAIL js_instr: got %h/%h want %h/404", id_instr, id_pc4, mem_word(32'h400)); end
    endtask

    task automatic test_flush();
        // flush kills the IF/ID load but the PC still advances
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin bad++; $display("FAIL fl_bubble: got %b/%h want 0/0", id_valid, id_instr); end
        total++; if (imem_addr !== 32'h408) begin bad++; $display("FAIL fl_addr: got %h want 408", imem_addr); end
    endtask

    task automatic test_wrap();
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_pre_addr: got %h want fffffffc", imem_addr); end
        step();
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wr_addr: got %h want 0", imem_addr); end
        total++; if (id_pc4 !== 32'h0 || id_valid !== 1'b1) begin bad++; $display("FAIL wr_pc4: got %h/%b want 0/1", id_pc4, id_valid); end
        total++; if (id_instr !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wr_instr: got %h want %h", id_instr, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic test_reset_mid();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (imem_addr !== 32'h0 || imem_req !== 1'b0) begin bad++; $display("FAIL rm_pc: got %h/%b want 0/0", imem_addr, imem_req); end
        total++; if (id_valid !== 1'b0 || id_pc4 !== 32'h0) begin bad++; $display("FAIL rm_ifid: got %b/%h want 0/0", id_valid, id_pc4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_not_ready();
        test_stall();
        test_branch();
        test_jump_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
